// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory between a fetch port and a
// load/store port. Round-robin on ties, registered memory request fields,
// one-cycle ready pulse per access, watchdog abort for accesses that hang.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ready,
  output logic            err,
  output logic            err_sticky
);

  localparam int MW = DW / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;     // 1 = data port was granted last
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [MW-1:0]   m_wmask_q, m_wmask_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            resp_d_q, resp_d_d;     // RESP belongs to the data port
  logic            abort_q, abort_d;
  logic            err_sticky_q, err_sticky_d;

  logic            grant_i, grant_d;
  logic            wd_expired;

  // On a tie the port that was not granted last wins.
  assign grant_d    = d_req && (!i_req || !last_d_q);
  assign grant_i    = i_req && !grant_d;
  assign wd_expired = (wd_cnt_q == CW'(TIMEOUT - 1));

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_d_q     <= 1'b0;
      wd_cnt_q     <= '0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wmask_q    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      resp_d_q     <= 1'b0;
      abort_q      <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      wd_cnt_q     <= wd_cnt_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wmask_q    <= m_wmask_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      resp_d_q     <= resp_d_d;
      abort_q      <= abort_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Next-state: grant, wait for memory or watchdog, then one response cycle.
  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    wd_cnt_d     = wd_cnt_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wmask_d    = m_wmask_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    resp_d_d     = resp_d_q;
    abort_d      = abort_q;
    err_sticky_d = err_sticky_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d   = BUSY_I;
          last_d_d  = 1'b0;
          wd_cnt_d  = '0;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          m_wmask_d = '0;
        end else if (grant_d) begin
          state_d   = BUSY_D;
          last_d_d  = 1'b1;
          wd_cnt_d  = '0;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_wmask_d = d_wmask;
        end
      end
      BUSY_I, BUSY_D: begin
        // m_ready takes priority over an expiring watchdog in the same cycle.
        if (m_ready) begin
          state_d  = RESP;
          abort_d  = 1'b0;
          resp_d_d = (state_q == BUSY_D);
          if (state_q == BUSY_I) i_rdata_d = m_rdata;
          else                   d_rdata_d = m_we_q ? '0 : m_rdata;
        end else if (wd_expired) begin
          state_d  = RESP;
          abort_d  = 1'b1;
          resp_d_d = (state_q == BUSY_D);
          if (state_q == BUSY_I) i_rdata_d = '0;
          else                   d_rdata_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d      = IDLE;
        err_sticky_d = err_sticky_q | abort_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state so m_req drops with an asynchronous reset.
  always_comb begin
    m_req      = (state_q == BUSY_I) || (state_q == BUSY_D);
    i_ready    = (state_q == RESP) && !resp_d_q;
    d_ready    = (state_q == RESP) && resp_d_q;
    err        = (state_q == RESP) && abort_q;
    m_we       = m_we_q;
    m_addr     = m_addr_q;
    m_wdata    = m_wdata_q;
    m_wmask    = m_wmask_q;
    i_rdata    = i_rdata_q;
    d_rdata    = d_rdata_q;
    err_sticky = err_sticky_q;
  end

endmodule
